// File: rtl/hmem_arbiter_pkg.sv
// Shared types for the higher-memory arbiter: memory operation encoding, arbiter FSM states,
// port count and the grant-state helper.
package hmem_arbiter_pkg;

    localparam int HMEM_ARB_PORTS = 2;
    localparam int PERF_CNT_W     = 32;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } hmem_arb_state_e;

    function automatic hmem_arb_state_e grant_state(input logic port);
        return port ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/hmem_arbiter_perf_counter.sv
// Saturating event counter: counts inc_i cycles, holds at all-ones, clears on reset.
module hmem_arb_perf_counter
    import hmem_arbiter_pkg::*;
#(
    parameter int WIDTH = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hmem_arbiter.sv
// Two-port burst-locking arbiter (port 0 = I-cache, port 1 = D-cache) onto one higher-memory port.
// Optional performance counters are built when HMEM_ARB_PERF_EN is defined.
module hmem_arbiter
    import hmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [HMEM_ARB_PORTS-1:0] c_req_valid,
    input  memory_operation_e         c_req_operation   [HMEM_ARB_PORTS],
    input  logic [ADDR_W-1:0]         c_req_address     [HMEM_ARB_PORTS],
    input  logic [DATA_W-1:0]         c_req_store_word  [HMEM_ARB_PORTS],
    output logic [DATA_W-1:0]         c_req_loaded_word [HMEM_ARB_PORTS],
    output logic [HMEM_ARB_PORTS-1:0] c_req_fulfilled,
    output logic                      m_req_valid,
    output memory_operation_e         m_req_operation,
    output logic [ADDR_W-1:0]         m_req_address,
    output logic [DATA_W-1:0]         m_req_store_word,
    input  logic [DATA_W-1:0]         m_req_loaded_word,
    input  logic                      m_req_fulfilled
`ifdef HMEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]     perf_bursts       [HMEM_ARB_PORTS],
    output logic [PERF_CNT_W-1:0]     perf_wait_cycles  [HMEM_ARB_PORTS]
`endif
);

    hmem_arb_state_e state_q;
    hmem_arb_state_e state_d;
    logic            rr_last_q;
    logic            rr_last_d;

    logic                      owner_valid;
    logic                      owner_idx;
    logic                      other_idx;
    logic [HMEM_ARB_PORTS-1:0] owner_onehot;

    always_comb begin
        owner_onehot[0] = (state_q == ST_GRANT0);
        owner_onehot[1] = (state_q == ST_GRANT1);
        owner_valid     = |owner_onehot;
        owner_idx       = owner_onehot[1];
        other_idx       = ~owner_idx;
    end

    // The grant only moves when the owner drops valid; a waiting port can hop in with no idle cycle.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (&c_req_valid) begin
                    state_d = grant_state(~rr_last_q);
                end else if (c_req_valid[0]) begin
                    state_d = ST_GRANT0;
                end else if (c_req_valid[1]) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!c_req_valid[owner_idx]) begin
                    rr_last_d = owner_idx;
                    state_d   = c_req_valid[other_idx] ? grant_state(other_idx) : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    always_comb begin
        m_req_valid      = 1'b0;
        m_req_operation  = LOAD;
        m_req_address    = '0;
        m_req_store_word = '0;
        if (owner_valid) begin
            m_req_valid      = c_req_valid[owner_idx];
            m_req_operation  = c_req_operation[owner_idx];
            m_req_address    = c_req_address[owner_idx];
            m_req_store_word = c_req_store_word[owner_idx];
        end
    end

    // Memory responses reach only the owner; anything arriving while idle is dropped.
    generate
        for (genvar gi = 0; gi < HMEM_ARB_PORTS; gi++) begin : g_resp
            assign c_req_fulfilled[gi]   = owner_onehot[gi] & m_req_fulfilled;
            assign c_req_loaded_word[gi] = owner_onehot[gi] ? m_req_loaded_word : '0;
        end
    endgenerate

`ifdef HMEM_ARB_PERF_EN
    logic [HMEM_ARB_PORTS-1:0] next_onehot;
    logic [HMEM_ARB_PORTS-1:0] grant_evt;
    logic [HMEM_ARB_PORTS-1:0] wait_evt;

    always_comb begin
        next_onehot[0] = (state_d == ST_GRANT0);
        next_onehot[1] = (state_d == ST_GRANT1);
        grant_evt      = next_onehot & ~owner_onehot;
        wait_evt       = c_req_valid & ~owner_onehot;
    end

    generate
        for (genvar gi = 0; gi < HMEM_ARB_PORTS; gi++) begin : g_perf
            hmem_arb_perf_counter #(.WIDTH(PERF_CNT_W)) u_bursts (
                .clk     (clk),
                .reset_n (reset_n),
                .inc_i   (grant_evt[gi]),
                .count_o (perf_bursts[gi])
            );
            hmem_arb_perf_counter #(.WIDTH(PERF_CNT_W)) u_wait (
                .clk     (clk),
                .reset_n (reset_n),
                .inc_i   (wait_evt[gi]),
                .count_o (perf_wait_cycles[gi])
            );
        end
    endgenerate
`endif

    a_fulfilled_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(c_req_fulfilled));
    a_valid_needs_owner: assert property (@(posedge clk) disable iff (!reset_n)
        m_req_valid |-> (state_q != ST_IDLE));

endmodule

// File: tb/tb_hmem_arbiter.sv
// Directed bench for hmem_arbiter; the perf-counter scenario is built when HMEM_ARB_PERF_EN is defined.
module tb_hmem_arbiter;
    import hmem_arbiter_pkg::*;

    logic              clk;
    logic              reset_n;
    logic [1:0]        c_req_valid;
    memory_operation_e c_req_operation   [2];
    logic [31:0]       c_req_address     [2];
    logic [31:0]       c_req_store_word  [2];
    logic [31:0]       c_req_loaded_word [2];
    logic [1:0]        c_req_fulfilled;
    logic              m_req_valid;
    memory_operation_e m_req_operation;
    logic [31:0]       m_req_address;
    logic [31:0]       m_req_store_word;
    logic [31:0]       m_req_loaded_word;
    logic              m_req_fulfilled;
`ifdef HMEM_ARB_PERF_EN
    logic [31:0]       perf_bursts      [2];
    logic [31:0]       perf_wait_cycles [2];
`endif

    int checks = 0;
    int errors = 0;

    hmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .c_req_valid       (c_req_valid),
        .c_req_operation   (c_req_operation),
        .c_req_address     (c_req_address),
        .c_req_store_word  (c_req_store_word),
        .c_req_loaded_word (c_req_loaded_word),
        .c_req_fulfilled   (c_req_fulfilled),
        .m_req_valid       (m_req_valid),
        .m_req_operation   (m_req_operation),
        .m_req_address     (m_req_address),
        .m_req_store_word  (m_req_store_word),
        .m_req_loaded_word (m_req_loaded_word),
        .m_req_fulfilled   (m_req_fulfilled)
`ifdef HMEM_ARB_PERF_EN
        ,
        .perf_bursts       (perf_bursts),
        .perf_wait_cycles  (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c_req_valid       = 2'b00;
        m_req_fulfilled   = 1'b0;
        m_req_loaded_word = '0;
        for (int p = 0; p < 2; p++) begin
            c_req_operation[p]  = LOAD;
            c_req_address[p]    = '0;
            c_req_store_word[p] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #2;
        checks++;
        if (m_req_valid !== 1'b0 || m_req_address !== 32'h0 || m_req_operation !== LOAD) begin
            errors++;
            $display("FAIL reset_m_outputs: valid=%0b addr=%h op=%0d required 0/0/LOAD",
                     m_req_valid, m_req_address, m_req_operation);
        end
        checks++;
        if (c_req_fulfilled !== 2'b00 || dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: fulfilled=%b state=%0d required 00/IDLE",
                     c_req_fulfilled, dut.state_q);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_burst();
        int pulses;
        int beat;
        pulses = 0;
        beat   = 0;
        c_req_operation[0] = LOAD;
        c_req_address[0]   = 32'h100;
        c_req_valid        = 2'b01;
        #1;
        checks++;
        if (m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_latency: m_req_valid=%0b required 0 in request cycle", m_req_valid);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            c_req_address[0]  = 32'h100 + 32'(4 * beat);
            m_req_fulfilled   = (i % 2) == 1;
            m_req_loaded_word = 32'hA000_0000 + 32'(i);
            #1;
            checks++;
            if (m_req_valid !== 1'b1 || m_req_address !== 32'h100 + 32'(4 * beat) ||
                c_req_fulfilled !== {1'b0, m_req_fulfilled} ||
                c_req_loaded_word[0] !== 32'hA000_0000 + 32'(i) || c_req_loaded_word[1] !== 32'h0) begin
                errors++;
                $display("FAIL burst_beat%0d: valid=%0b addr=%h ful=%b lw0=%h lw1=%h required 1/%h/%b/%h/0",
                         i, m_req_valid, m_req_address, c_req_fulfilled, c_req_loaded_word[0],
                         c_req_loaded_word[1], 32'h100 + 32'(4 * beat), {1'b0, m_req_fulfilled},
                         32'hA000_0000 + 32'(i));
            end
            pulses += int'(c_req_fulfilled[0]);
            if (m_req_fulfilled) beat++;
            tick();
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL burst_pulses: saw %0d fulfilled[0] pulses required 4", pulses);
        end
        c_req_valid     = 2'b00;
        m_req_fulfilled = 1'b0;
        #1;
        checks++;
        if (m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_release: m_req_valid=%0b required 0", m_req_valid);
        end
        tick();
        $display("test_burst done (port0 LOAD 0x100, 4 beats)");
    endtask

    task automatic test_round_robin();
        do_reset();
        c_req_address[0] = 32'h300;
        c_req_address[1] = 32'h400;
        c_req_valid      = 2'b11;
        tick();
        checks++;
        if (m_req_valid !== 1'b1 || m_req_address !== 32'h300) begin
            errors++;
            $display("FAIL rr_first_port0: valid=%0b addr=%h required 1/00000300", m_req_valid, m_req_address);
        end
        tick();
        c_req_valid = 2'b10;
        #1;
        checks++;
        if (m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_release_cycle: m_req_valid=%0b required 0", m_req_valid);
        end
        tick();
        m_req_fulfilled   = 1'b1;
        m_req_loaded_word = 32'h5555_AAAA;
        #1;
        checks++;
        if (m_req_valid !== 1'b1 || m_req_address !== 32'h400 || c_req_fulfilled !== 2'b10 ||
            c_req_loaded_word[1] !== 32'h5555_AAAA || c_req_loaded_word[0] !== 32'h0) begin
            errors++;
            $display("FAIL rr_handover_port1: valid=%0b addr=%h ful=%b lw1=%h lw0=%h required 1/400/10/5555aaaa/0",
                     m_req_valid, m_req_address, c_req_fulfilled, c_req_loaded_word[1], c_req_loaded_word[0]);
        end
        m_req_fulfilled = 1'b0;
        c_req_valid     = 2'b00;
        tick();
        c_req_valid = 2'b11;
        tick();
        checks++;
        if (m_req_address !== 32'h300 || m_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_both_again_port0: valid=%0b addr=%h required 1/00000300", m_req_valid, m_req_address);
        end
        c_req_valid = 2'b00;
        tick();
        c_req_valid = 2'b11;
        tick();
        checks++;
        if (m_req_address !== 32'h400 || m_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_alternate_port1: valid=%0b addr=%h required 1/00000400", m_req_valid, m_req_address);
        end
        c_req_valid = 2'b00;
        tick();
        tick();
        $display("test_round_robin done");
    endtask

    task automatic test_lock();
        do_reset();
        c_req_operation[1]  = STORE;
        c_req_address[1]    = 32'h200;
        c_req_store_word[1] = 32'hDEAD_BEEF;
        c_req_valid         = 2'b10;
        tick();
        c_req_operation[0]  = LOAD;
        c_req_address[0]    = 32'h999;
        c_req_store_word[0] = 32'h1234_5678;
        c_req_valid         = 2'b11;
        for (int i = 0; i < 5; i++) begin
            m_req_fulfilled = (i % 2) == 0;
            #1;
            checks++;
            if (m_req_address !== 32'h200 || m_req_store_word !== 32'hDEAD_BEEF ||
                m_req_operation !== STORE || c_req_fulfilled[0] !== 1'b0) begin
                errors++;
                $display("FAIL lock_cycle%0d: addr=%h data=%h op=%0d ful0=%0b required 200/deadbeef/STORE/0",
                         i, m_req_address, m_req_store_word, m_req_operation, c_req_fulfilled[0]);
            end
            tick();
        end
        m_req_fulfilled = 1'b0;
        c_req_valid     = 2'b01;
        #1;
        checks++;
        if (m_req_valid !== 1'b0 || m_req_store_word === 32'h1234_5678) begin
            errors++;
            $display("FAIL lock_release: valid=%0b data=%h required 0 and not port0 data",
                     m_req_valid, m_req_store_word);
        end
        tick();
        checks++;
        if (m_req_address !== 32'h999 || m_req_operation !== LOAD || m_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_next_owner: addr=%h op=%0d valid=%0b required 999/LOAD/1",
                     m_req_address, m_req_operation, m_req_valid);
        end
        c_req_valid = 2'b00;
        tick();
        $display("test_lock done (port1 STORE 0x200)");
    endtask

    task automatic test_idle_fulfil();
        clear_inputs();
        tick();
        m_req_fulfilled   = 1'b1;
        m_req_loaded_word = 32'hFFFF_0000;
        #1;
        checks++;
        if (c_req_fulfilled !== 2'b00 || c_req_loaded_word[0] !== 32'h0 || c_req_loaded_word[1] !== 32'h0) begin
            errors++;
            $display("FAIL idle_fulfil_blocked: ful=%b lw0=%h lw1=%h required 00/0/0",
                     c_req_fulfilled, c_req_loaded_word[0], c_req_loaded_word[1]);
        end
        tick();
        m_req_fulfilled = 1'b0;
        checks++;
        if (dut.state_q !== ST_IDLE || m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_fulfil_state: state=%0d valid=%0b required IDLE/0", dut.state_q, m_req_valid);
        end
        $display("test_idle_fulfil done");
    endtask

    task automatic test_async_reset();
        do_reset();
        c_req_address[0] = 32'h500;
        c_req_address[1] = 32'h600;
        c_req_valid      = 2'b01;
        tick();
        c_req_valid = 2'b11;
        #1;
        checks++;
        if (m_req_valid !== 1'b1 || m_req_address !== 32'h500) begin
            errors++;
            $display("FAIL areset_pre: valid=%0b addr=%h required 1/00000500", m_req_valid, m_req_address);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_req_valid !== 1'b0 || m_req_address !== 32'h0 || dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL areset_immediate: valid=%0b addr=%h state=%0d required 0/0/IDLE",
                     m_req_valid, m_req_address, dut.state_q);
        end
        c_req_valid = 2'b10;
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (m_req_valid !== 1'b1 || m_req_address !== 32'h600) begin
            errors++;
            $display("FAIL areset_port1_first: valid=%0b addr=%h required 1/00000600", m_req_valid, m_req_address);
        end
        c_req_valid = 2'b00;
        tick();
        $display("test_async_reset done");
    endtask

`ifdef HMEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (perf_bursts[0] !== 32'd0 || perf_wait_cycles[1] !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: bursts0=%0d wait1=%0d required 0/0", perf_bursts[0], perf_wait_cycles[1]);
        end
        c_req_valid = 2'b01;
        tick();
        c_req_valid = 2'b11;
        for (int i = 0; i < 6; i++) tick();
        c_req_valid = 2'b10;
        tick();
        checks++;
        if (perf_wait_cycles[1] !== 32'd7 || perf_bursts[0] !== 32'd1 || perf_bursts[1] !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts: wait1=%0d bursts0=%0d bursts1=%0d required 7/1/1",
                     perf_wait_cycles[1], perf_bursts[0], perf_bursts[1]);
        end
        tick();
        checks++;
        if (perf_wait_cycles[1] !== 32'd7 || perf_wait_cycles[0] !== 32'd1) begin
            errors++;
            $display("FAIL perf_owner_no_wait: wait1=%0d wait0=%0d required 7/1",
                     perf_wait_cycles[1], perf_wait_cycles[0]);
        end
        c_req_valid = 2'b00;
        tick();
        $display("test_perf done");
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_round_robin();
        test_lock();
        test_idle_fulfil();
        test_async_reset();
`ifdef HMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
